// File: rtl/jam.sv
// Exhaustive 8x8 job-assignment solver: loads a cost ROM, scores all 8! permutations,
// reports minimum total cost and tie count. Define MATCHCOUNT_SAT_EN to saturate the count at 15.
module jam (
  input  logic       CLK,
  input  logic       RST,
  output logic [2:0] W,
  output logic [2:0] J,
  input  logic [6:0] Cost,
  output logic [3:0] MatchCount,
  output logic [8:0] MinCost,
  output logic       Valid
);

  typedef enum logic [1:0] {LOAD, EVAL, DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [6:0] r_lcnt;
  logic [6:0] r_tab [64];
  logic [2:0] r_perm [8];
  logic [2:0] w_perm_nxt [8];
  logic [2:0] w_swp [8];
  logic [2:0] w_i, w_j;
  logic       w_more;
  logic [9:0] r_min, w_sum;
  logic [3:0] r_cnt, w_cnt_inc;

  always_comb begin
    w_sum = '0;
    for (int unsigned w = 0; w < 8; w++)
      w_sum = w_sum + {3'b000, r_tab[{w[2:0], r_perm[w[2:0]]}]};
  end

  // Lexicographic successor: pivot i, rightmost larger j, swap, then reverse the suffix after i.
  always_comb begin
    w_more = 1'b0;
    w_i    = '0;
    w_j    = '0;
    for (int unsigned k = 0; k < 7; k++)
      if (r_perm[k[2:0]] < r_perm[3'(k + 1)]) begin
        w_more = 1'b1;
        w_i    = k[2:0];
      end
    for (int unsigned k = 1; k < 8; k++)
      if ((k[2:0] > w_i) && (r_perm[k[2:0]] > r_perm[w_i]))
        w_j = k[2:0];
    w_swp      = r_perm;
    w_swp[w_i] = r_perm[w_j];
    w_swp[w_j] = r_perm[w_i];
    w_perm_nxt = w_swp;
    for (int unsigned k = 0; k < 8; k++)
      if (k[2:0] > w_i)
        w_perm_nxt[k[2:0]] = w_swp[3'(32'(w_i) + 32'd8 - k)];
  end

`ifdef MATCHCOUNT_SAT_EN
  assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
`else
  assign w_cnt_inc = r_cnt + 4'd1;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= LOAD;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (r_lcnt == 7'd64) w_state_nxt = EVAL;
      EVAL:    if (!w_more)         w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = LOAD;
    endcase
  end

  // The first edge after release only primes the ROM with address 0; captures trail the address by one edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_lcnt     <= '0;
      W          <= '0;
      J          <= '0;
      r_min      <= '1;
      r_cnt      <= '0;
      Valid      <= 1'b0;
      MinCost    <= '0;
      MatchCount <= '0;
      for (int unsigned k = 0; k < 8; k++) r_perm[k[2:0]] <= k[2:0];
    end else begin
      case (r_state)
        LOAD: begin
          r_lcnt <= r_lcnt + 7'd1;
          {W, J} <= r_lcnt[5:0];
        end
        EVAL: begin
          r_perm <= w_perm_nxt;
          if (w_sum < r_min) begin
            r_min <= w_sum;
            r_cnt <= 4'd1;
          end else if (w_sum == r_min) begin
            r_cnt <= w_cnt_inc;
          end
        end
        DONE: begin
          Valid      <= 1'b1;
          MinCost    <= r_min[8:0];
          MatchCount <= r_cnt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if ((r_state == LOAD) && (r_lcnt != 7'd0))
      r_tab[6'(r_lcnt - 7'd1)] <= Cost;
  end

endmodule

// File: tb/tb_jam.sv
// Self-checking bench for jam: table of ROM scenarios, scoreboard of expected results,
// per-cycle address sweep and Valid latency checks, and an abort by reset mid-evaluation.
module tb_jam;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [2:0] W, J;
  logic [6:0] Cost = '0;
  logic [3:0] MatchCount;
  logic [8:0] MinCost;
  logic       Valid;

  logic [6:0] rom [64];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {int mode; int abort_at; int exp_min; int exp_cnt;} vec_t;
  typedef struct {int min; int cnt;} res_t;

  vec_t vecs [3];
  res_t sb [$];

  jam dut (
    .CLK(CLK), .RST(RST), .W(W), .J(J), .Cost(Cost),
    .MatchCount(MatchCount), .MinCost(MinCost), .Valid(Valid)
  );

  always #5 CLK = ~CLK;

  // ROM samples its address on the falling edge; data is stable at the next rising edge.
  always @(negedge CLK) Cost = rom[{W, J}];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mode 0: only the anti-diagonal is free (last permutation is the unique optimum)
  // mode 1: two optima (identity and swap of workers 0/1)
  // mode 2: cost equals job index, every assignment totals 28
  task automatic fill(input int mode);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) begin
        case (mode)
          0: rom[w*8+j] = (j == 7 - w) ? 7'd0 : 7'd100;
          1: rom[w*8+j] = ((w >= 2 && j == w) || (w < 2 && j < 2)) ? 7'd0 : 7'd100;
          default: rom[w*8+j] = 7'(j);
        endcase
      end
  endtask

  initial begin
    int sat_cnt;
`ifdef MATCHCOUNT_SAT_EN
    sat_cnt = 15;
`else
    sat_cnt = 0;
`endif
    vecs[0] = '{0, 0,    0,  1};
    vecs[1] = '{1, 2000, 0,  2};
    vecs[2] = '{2, 0,    28, sat_cnt};

    for (int v = 0; v < 3; v++) begin
      int first, leak, drop;
      res_t r;
      #2 RST = 1'b0;
      #1;
      check($sformatf("rst%0d_W", v),          int'(W),          0);
      check($sformatf("rst%0d_J", v),          int'(J),          0);
      check($sformatf("rst%0d_MinCost", v),    int'(MinCost),    0);
      check($sformatf("rst%0d_MatchCount", v), int'(MatchCount), 0);
      check($sformatf("rst%0d_Valid", v),      int'(Valid),      0);
      fill(vecs[v].mode);
      if (vecs[v].abort_at == 0) sb.push_back('{vecs[v].exp_min, vecs[v].exp_cnt});

      @(negedge CLK);
      RST = 1'b1;
      #1 check($sformatf("run%0d_addr_e0", v), int'({W, J}), 0);

      first = 0;
      leak  = 0;
      drop  = 0;
      for (int e = 1; e <= 41000; e++) begin
        @(posedge CLK);
        #1;
        if (e <= 70) check($sformatf("run%0d_addr_e%0d", v, e), int'({W, J}), (e <= 64) ? e - 1 : 0);
        else if ({W, J} != 6'd0) leak++;
        if (Valid) begin
          if (first == 0) first = e;
        end else begin
          if (first != 0) drop++;
          if (MinCost != 9'd0 || MatchCount != 4'd0) leak++;
        end
        if (vecs[v].abort_at != 0 && e == 65 + vecs[v].abort_at) break;
        if (first != 0 && e >= first + 4) break;
      end

      check($sformatf("run%0d_leak", v), leak, 0);
      if (vecs[v].abort_at != 0) begin
        check($sformatf("run%0d_valid_early", v), first, 0);
      end else begin
        check($sformatf("run%0d_valid_edge", v), first, 40386);
        check($sformatf("run%0d_valid_drop", v), drop, 0);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL run%0d_scoreboard: got empty queue expected one result", v);
        end else begin
          r = sb.pop_front();
          check($sformatf("run%0d_MinCost", v),    int'(MinCost),    r.min);
          check($sformatf("run%0d_MatchCount", v), int'(MatchCount), r.cnt);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
